bnn_uart_cmd_ctrl: RTL and testbench

Parametrised UART command controller between the host serial link and the BNN core. It contains a baud-timed receiver with RTS/CTS flow control, a receive FIFO, a command FSM and a transmitter. The FSM loads image bytes into the core, starts inference, and returns results, status, or ACK/ERR codes. It is the next-generation controller: configurable bit timing, FIFO depth and image size, plus framing/overrun detection.

---
 rtl/bnn_uart_pkg.sv | 25 ++
 rtl/bnn_sync_fifo.sv | 52 +++++
 rtl/bnn_uart_cmd_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_bnn_uart_cmd_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_uart_pkg.sv
// Shared types and constants for the BNN UART command controller:
// FSM state encoding, command opcodes and response codes.
package bnn_uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    RESPOND = 2'd3
  } state_e;

  localparam logic [7:0] OP_LOAD   = 8'h01;
  localparam logic [7:0] OP_START  = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;

  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  // The FSM is never busy while it is decoding STATUS, so bit 3 is always 0.
  function automatic logic [7:0] status_byte(input logic overrun, input logic frame_err,
                                             input logic img_loaded);
    return {4'b0000, 1'b0, overrun, frame_err, img_loaded};
  endfunction

endpackage

// File: rtl/bnn_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read data; a push while full
// is accepted only when a pop happens in the same cycle.
module bnn_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bnn_uart_cmd_ctrl.sv
// UART command controller: 8N1 receiver with CTS, RX FIFO, command FSM that
// loads images / starts inference / reports status, and an RTS-gated transmitter.
module bnn_uart_cmd_ctrl
  import bnn_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter int IMG_BYTES    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_rx,
  input  logic                   uart_rts,
  output logic                   uart_tx,
  output logic                   uart_cts,
  output logic [IMG_BYTES*8-1:0] img_data,
  output logic                   img_valid,
  output logic                   bnn_start,
  input  logic                   bnn_done,
  input  logic [7:0]             bnn_result
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = (IMG_BYTES > 1) ? $clog2(IMG_BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    CTS_LIMIT = CW'(FIFO_DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(IMG_BYTES - 1);

  // ---------------- RX ----------------
  logic             rx_meta_q, rx_sync_q, rx_prev_q, rx_busy_q;
  logic [3:0]       rx_bit_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [7:0]       rx_shift_q;
  logic             rx_valid_q, rx_ferr_q;

  // rx_bit_q: 0 = start bit, 1..8 = data bits, 9 = stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_bit_q   <= '0;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      if (!rx_busy_q) begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_busy_q <= 1'b1;
          rx_bit_q  <= '0;
          rx_cnt_q  <= '0;
        end
      end else if (rx_bit_q == 4'd0) begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_q <= '0;
          if (rx_sync_q) rx_busy_q <= 1'b0;
          else           rx_bit_q  <= 4'd1;
        end else begin
          rx_cnt_q <= rx_cnt_q + 1'b1;
        end
      end else if (rx_cnt_q == CNT_LAST) begin
        rx_cnt_q <= '0;
        if (rx_bit_q == 4'd9) begin
          rx_busy_q  <= 1'b0;
          rx_valid_q <= rx_sync_q;
          rx_ferr_q  <= !rx_sync_q;
        end else begin
          rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 1'b1;
        end
      end else begin
        rx_cnt_q <= rx_cnt_q + 1'b1;
      end
    end
  end

  // ---------------- FIFO + flow control ----------------
  state_e        state_q, state_d;
  logic [7:0]    fifo_data;
  logic          fifo_full, fifo_empty, fifo_pop, overrun_set, cts_q;
  logic [CW-1:0] fifo_count;

  assign fifo_pop    = !fifo_empty && (state_q == IDLE || state_q == LOAD);
  assign overrun_set = rx_valid_q && fifo_full && !fifo_pop;

  bnn_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (rx_valid_q),
    .data_i (rx_shift_q),
    .pop_i  (fifo_pop),
    .data_o (fifo_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cts_q <= 1'b0;
    else     cts_q <= (fifo_count < CTS_LIMIT);
  end
  assign uart_cts = cts_q;

  // ---------------- TX ----------------
  logic             tx_q, tx_busy_q, tx_launch, tx_idle;
  logic [3:0]       tx_bit_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [8:0]       tx_shift_q;
  logic [7:0]       rsp_q, rsp_d;

  // Idle includes the last stop-bit cycle so frames can run back to back.
  assign tx_idle = !tx_busy_q || (tx_bit_q == 4'd9 && tx_cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
      tx_shift_q <= '1;
    end else if (tx_launch) begin
      tx_q       <= 1'b0;
      tx_busy_q  <= 1'b1;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
      tx_shift_q <= {1'b1, rsp_q};
    end else if (tx_busy_q) begin
      if (tx_cnt_q == CNT_LAST) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
        end else begin
          tx_bit_q   <= tx_bit_q + 1'b1;
          tx_q       <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[8:1]};
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end
  assign uart_tx = tx_q;

  // ---------------- Command FSM ----------------
  logic [IMG_BYTES*8-1:0] img_q, img_d, buf_q, buf_d, load_buf;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic loaded_q, loaded_d, valid_q, valid_d, start_q, start_d;
  logic ferr_q, ferr_d, ovr_q, ovr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rsp_q    <= '0;
      img_q    <= '0;
      buf_q    <= '0;
      idx_q    <= '0;
      loaded_q <= 1'b0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rsp_q    <= rsp_d;
      img_q    <= img_d;
      buf_q    <= buf_d;
      idx_q    <= idx_d;
      loaded_q <= loaded_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rsp_d     = rsp_q;
    img_d     = img_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    loaded_d  = loaded_q;
    valid_d   = 1'b0;
    start_d   = 1'b0;
    tx_launch = 1'b0;
    ferr_d    = ferr_q | rx_ferr_q;
    ovr_d     = ovr_q | overrun_set;
    load_buf  = buf_q;
    load_buf[idx_q*8 +: 8] = fifo_data;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          case (fifo_data)
            OP_LOAD: begin
              state_d = LOAD;
              idx_d   = '0;
            end
            OP_START: begin
              if (loaded_q) begin
                state_d = RUN;
                start_d = 1'b1;
              end else begin
                rsp_d   = RSP_ERR;
                state_d = RESPOND;
              end
            end
            OP_STATUS: begin
              // A flag event landing in this very cycle survives the clear.
              rsp_d   = status_byte(ovr_q, ferr_q, loaded_q);
              ferr_d  = rx_ferr_q;
              ovr_d   = overrun_set;
              state_d = RESPOND;
            end
            default: begin
              rsp_d   = RSP_ERR;
              state_d = RESPOND;
            end
          endcase
        end
      end
      LOAD: begin
        if (!fifo_empty) begin
          buf_d = load_buf;
          if (idx_q == IDX_LAST) begin
            img_d    = load_buf;
            valid_d  = 1'b1;
            loaded_d = 1'b1;
            rsp_d    = RSP_ACK;
            state_d  = RESPOND;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (bnn_done && !start_q) begin
          rsp_d   = bnn_result;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        if (tx_idle && uart_rts) begin
          tx_launch = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign img_data  = img_q;
  assign img_valid = valid_q;
  assign bnn_start = start_q;

endmodule

// File: tb/tb_bnn_uart_cmd_ctrl.sv
// Self-checking bench for bnn_uart_cmd_ctrl: host UART driver, core stub,
// command-level reference model and decoupled TX/image/start monitors.
`timescale 1ns/1ps
module tb_bnn_uart_cmd_ctrl;
  import bnn_uart_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int IMG   = 4;

  logic             clk = 1'b0;
  logic             rst, uart_rx, uart_rts, uart_tx, uart_cts;
  logic [IMG*8-1:0] img_data;
  logic             img_valid, bnn_start, bnn_done;
  logic [7:0]       bnn_result;

  bnn_uart_cmd_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .IMG_BYTES(IMG)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .uart_rts  (uart_rts),
    .uart_tx   (uart_tx),
    .uart_cts  (uart_cts),
    .img_data  (img_data),
    .img_valid (img_valid),
    .bnn_start (bnn_start),
    .bnn_done  (bnn_done),
    .bnn_result(bnn_result)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0]       exp_q[$];
  logic [IMG*8-1:0] exp_img_q[$];
  logic [7:0]       res_q[$];
  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int frames_seen = 0;
  logic mon_en = 1'b0;
  logic mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (command level) ----------------
  logic       m_loaded = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  logic       m_collect = 1'b0, m_blocked = 1'b0, m_holding = 1'b0;
  logic [7:0] m_pay[$];
  logic [7:0] m_pend[$];
  logic [7:0] m_next_res = 8'h00;
  int         m_starts = 0;

  function automatic void model_decode(input logic [7:0] b);
    logic [IMG*8-1:0] img;
    if (m_collect) begin
      m_pay.push_back(b);
      if (m_pay.size() == IMG) begin
        for (int k = 0; k < IMG; k++) img[8*k +: 8] = m_pay[k];
        exp_img_q.push_back(img);
        m_loaded  = 1'b1;
        m_collect = 1'b0;
        m_pay.delete();
        exp_q.push_back(8'hA5);
      end
    end else if (b == 8'h01) begin
      m_collect = 1'b1;
    end else if (b == 8'h02) begin
      if (m_loaded) begin
        res_q.push_back(m_next_res);
        exp_q.push_back(m_next_res);
        m_starts++;
      end else begin
        exp_q.push_back(8'hEE);
      end
    end else if (b == 8'h03) begin
      exp_q.push_back({4'h0, 1'b0, m_ovr, m_ferr, m_loaded});
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end else begin
      exp_q.push_back(8'hEE);
    end
  endfunction

  // While responses are blocked the controller holds one decoded command and
  // the queue absorbs DEPTH more; anything beyond that is lost as an overrun.
  function automatic void model_host(input logic [7:0] b);
    if (!m_blocked) model_decode(b);
    else if (!m_holding) begin
      model_decode(b);
      m_holding = 1'b1;
    end else if (m_pend.size() < DEPTH) m_pend.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  function automatic void model_release();
    m_blocked = 1'b0;
    m_holding = 1'b0;
    while (m_pend.size() > 0) model_decode(m_pend.pop_front());
  endfunction

  // ---------------- drivers ----------------
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    if (!stop_bit) repeat (CPB) @(negedge clk);
  endtask

  task automatic host_send(input logic [7:0] b);
    model_host(b);
    send_frame(b, 1'b1);
  endtask

  task automatic host_send_bad(input logic [7:0] b);
    m_ferr = 1'b1;
    send_frame(b, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || exp_img_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size() + exp_img_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_tx_low(input int budget);
    int n = 0;
    while (uart_tx && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", uart_tx, 1'b0);
  endtask

  // ---------------- core stub ----------------
  initial begin : core_stub
    bnn_done   = 1'b0;
    bnn_result = 8'h00;
    forever begin
      @(negedge clk);
      if (bnn_start && res_q.size() > 0) begin
        logic [7:0] r;
        r = res_q.pop_front();
        repeat (50) @(negedge clk);
        bnn_result = r;
        bnn_done   = 1'b1;
        @(negedge clk);
        bnn_done   = 1'b0;
        bnn_result = 8'($urandom_range(0, 255));
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) if (bnn_start) start_cnt++;

  always @(negedge clk) begin
    if (img_valid) begin
      if (exp_img_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL img_unexpected actual=%h required=none", img_data);
      end else begin
        check("img_data", img_data, exp_img_q.pop_front());
      end
    end
  end

  initial begin : tx_mon
    logic [7:0] got;
    got = '0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && uart_tx == 1'b0) begin
        mon_busy = 1'b1;
        repeat (CPB/2 - 1) @(negedge clk);
        check("tx_start_bit", uart_tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          got[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", uart_tx, 1'b1);
        frames_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected actual=%h required=none", got);
        end else begin
          check("tx_byte", got, exp_q.pop_front());
        end
        repeat (CPB/2 - 1) @(negedge clk);
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #(600_000);
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin : main_seq
    int fr;
    rst      = 1'b1;
    uart_rx  = 1'b1;
    uart_rts = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_uart_cts", uart_cts, 1'b0);
    check("rst_img_data", img_data, '0);
    check("rst_img_valid", img_valid, 1'b0);
    check("rst_bnn_start", bnn_start, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("cts_after_release", uart_cts, 1'b1);

    // Reset in the middle of a response frame.
    send_frame(8'h5A, 1'b1);
    wait_tx_low(400);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_uart_tx", uart_tx, 1'b1);
    check("midreset_uart_cts", uart_cts, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_cts_release", uart_cts, 1'b1);
    repeat (200) @(negedge clk);
    mon_en = 1'b1;

    // Error reporting from a fresh reset.
    host_send_bad(8'($urandom_range(0, 255)));
    host_send(OP_STATUS);
    host_send(OP_STATUS);
    host_send(8'h5A);
    host_send(OP_START);
    wait_drain(2000);
    check("no_start_unloaded", start_cnt, 0);

    // Directed LOAD then START.
    host_send(OP_LOAD);
    host_send(8'h11);
    host_send(8'h22);
    host_send(8'h33);
    host_send(8'h44);
    wait_drain(2000);
    check("img_directed", img_data, 32'h44332211);
    m_next_res = 8'h07;
    host_send(OP_START);
    wait_drain(2000);
    check("start_once", start_cnt, 1);

    // Randomised command mix.
    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          host_send(OP_LOAD);
          for (int k = 0; k < IMG; k++) host_send(8'($urandom_range(0, 255)));
        end
        1: begin
          m_next_res = 8'($urandom_range(0, 255));
          host_send(OP_START);
        end
        2: host_send(OP_STATUS);
        3: host_send(8'($urandom_range(4, 255)));
        default: host_send_bad(8'($urandom_range(0, 255)));
      endcase
    end
    wait_drain(4000);
    check("start_count_random", start_cnt, m_starts);

    // Flow control: responses blocked, six STATUS bytes streamed.
    @(negedge clk);
    uart_rts  = 1'b0;
    m_blocked = 1'b1;
    for (int k = 0; k < 6; k++) begin
      host_send(OP_STATUS);
      if (k == 2) check("cts_high_count2", uart_cts, 1'b1);
      if (k == 3) check("cts_low_count3", uart_cts, 1'b0);
    end
    check("cts_low_full", uart_cts, 1'b0);
    check("tx_held_idle", uart_tx, 1'b1);
    model_release();
    uart_rts = 1'b1;
    wait_drain(4000);
    check("cts_after_drain", uart_cts, 1'b1);

    // RTS dropped during a frame: frame completes, the next one waits.
    host_send(OP_STATUS);
    wait_tx_low(400);
    repeat (40) @(negedge clk);
    uart_rts = 1'b0;
    host_send(8'h5A);
    fr = 0;
    while ((exp_q.size() != 1 || mon_busy) && fr < 400) begin
      @(negedge clk);
      fr++;
    end
    fr = frames_seen;
    repeat (300) @(negedge clk);
    check("rts_hold_pending", exp_q.size(), 1);
    check("rts_hold_frames", frames_seen - fr, 0);
    check("rts_hold_tx_idle", uart_tx, 1'b1);
    uart_rts = 1'b1;
    wait_drain(2000);

    check("final_start_count", start_cnt, m_starts);
    check("final_res_q", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
